// File: rtl/rot_align_pkg.sv
// rot_align_pkg: shared types, sync constant and 8-bit rotate helpers for the rotation aligner.
package rot_align_pkg;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;
  typedef enum logic {ROT_L, ROT_R} rot_dir_e;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  function automatic logic [7:0] rotl8(input logic [7:0] d, input logic [2:0] amt);
    logic [15:0] t;
    t = {d, d} << amt;
    return t[15:8];
  endfunction
  function automatic logic [7:0] rotr8(input logic [7:0] d, input logic [2:0] amt);
    logic [15:0] t;
    t = {d, d} >> amt;
    return t[7:0];
  endfunction
endpackage

// File: rtl/rot8_unit.sv
// rot8_unit: combinational 8-bit rotator, left or right by amt.
module rot8_unit
  import rot_align_pkg::*;
(
  input  logic [7:0] data,
  input  logic [2:0] amt,
  input  rot_dir_e   dir,
  output logic [7:0] rot
);
  assign rot = (dir == ROT_L) ? rotl8(data, amt) : rotr8(data, amt);
endmodule

// File: rtl/rot_align_detector.sv
// rot_align_detector: finds the fixed right-rotation of a framed stream via its sync word,
// locks with hysteresis and emits realigned words.
module rot_align_detector
  import rot_align_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD   = SYNC_DEFAULT,
  parameter int         FRAME_LEN   = 4,
  parameter int         LOCK_HITS   = 2,
  parameter int         LOSS_MISSES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       locked,
  output logic [2:0] lock_amt,
  output logic       lock_lost
);
  localparam int PW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(LOCK_HITS + 1);
  localparam int MW = $clog2(LOSS_MISSES + 1);
  state_e        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [2:0]    cand_q, cand_d, hit_amt;
  logic          hit_any, slot, cand_match, sof_d, emit;
  logic [7:0]    realigned;
  always_comb begin
    hit_any = 1'b0;
    hit_amt = '0;
    for (int k = 0; k < 8; k++)
      if (in_data == rotr8(SYNC_WORD, 3'(k))) begin
        hit_any = 1'b1;
        hit_amt = 3'(k);
      end
  end
  assign slot       = pos_q == PW'(FRAME_LEN - 1);
  assign cand_match = in_data == rotr8(SYNC_WORD, cand_q);
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hits_d  = hits_q;
    miss_d  = miss_q;
    cand_d  = cand_q;
    sof_d   = 1'b0;
    if (in_valid)
      case (state_q)
        HUNT:
          if (hit_any) begin
            cand_d  = hit_amt;
            pos_d   = '0;
            hits_d  = HW'(1);
            miss_d  = '0;
            state_d = (LOCK_HITS == 1) ? LOCKED : VERIFY;
            sof_d   = LOCK_HITS == 1;
          end
        VERIFY:
          if (!slot) pos_d = pos_q + PW'(1);
          else if (cand_match) begin
            pos_d  = '0;
            hits_d = hits_q + HW'(1);
            if (hits_d == HW'(LOCK_HITS)) begin
              state_d = LOCKED;
              miss_d  = '0;
              sof_d   = 1'b1;
            end
          end else state_d = HUNT;
        default:
          if (!slot) pos_d = pos_q + PW'(1);
          else begin
            pos_d  = '0;
            miss_d = cand_match ? '0 : miss_q + MW'(1);
            sof_d  = cand_match;
            // Below the loss threshold a missed slot is still passed through as data.
            if (miss_d == MW'(LOSS_MISSES)) state_d = HUNT;
          end
      endcase
  end
  assign emit   = in_valid && state_d == LOCKED;
  assign locked = state_q == LOCKED;
  rot8_unit u_rot (
    .data(in_data),
    .amt (cand_d),
    .dir (ROT_L),
    .rot (realigned)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= HUNT;
      pos_q     <= '0;
      hits_q    <= '0;
      miss_q    <= '0;
      cand_q    <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_data  <= '0;
      lock_amt  <= '0;
      lock_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      hits_q    <= hits_d;
      miss_q    <= miss_d;
      cand_q    <= cand_d;
      out_valid <= emit;
      out_sof   <= emit && sof_d;
      lock_lost <= in_valid && state_q == LOCKED && state_d == HUNT;
      if (emit) out_data <= realigned;
      if (emit && state_q != LOCKED) lock_amt <= cand_d;
    end
endmodule

// File: tb/tb_rot_align_detector.sv
// tb_rot_align_detector: randomized and directed checks against a word-level reference model.
module tb_rot_align_detector;
  localparam int SYNC = 'hA5;
  localparam int FL = 4;
  localparam int LH = 2;
  localparam int LM = 2;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0, out_data, lock_amt_w;
  logic out_valid, out_sof, locked, lock_lost;
  logic [2:0] lock_amt;
  int n_chk = 0, n_err = 0;
  int m_mode, m_amt, m_since, m_hits, m_miss;
  int e_valid, e_sof, e_lost, e_amt, e_data;
  int vcount, lock_at, lost_cnt;
  int emit_q[$], q1[$];
  int l1;
  rot_align_detector dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
    .locked(locked), .lock_amt(lock_amt), .lock_lost(lock_lost)
  );
  always #5 clk = ~clk;
  function automatic int rr(int x, int k);
    return ((x >> k) | (x << (8 - k))) & 255;
  endfunction
  function automatic int rl(int x, int k);
    return ((x << k) | (x >> (8 - k))) & 255;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_amt = 0; m_since = 0; m_hits = 0; m_miss = 0;
    e_valid = 0; e_sof = 0; e_lost = 0; e_amt = 0; e_data = 0;
  endtask
  task automatic emit(input int d, input int s);
    e_valid = 1; e_sof = s; e_data = rl(d, m_amt);
  endtask
  task automatic go_lock(input int d);
    m_mode = 2; m_miss = 0; e_amt = m_amt;
    emit(d, 1);
  endtask
  task automatic model_step(input bit v, input int d);
    int k;
    e_valid = 0; e_sof = 0; e_lost = 0;
    if (!v) return;
    k = -1;
    for (int i = 0; i < 8; i++) if (rr(SYNC, i) == d) k = i;
    if (m_mode == 0) begin
      if (k >= 0) begin
        m_amt = k; m_since = 0; m_hits = 1;
        if (m_hits >= LH) go_lock(d); else m_mode = 1;
      end
    end else begin
      m_since++;
      if (m_since == FL) begin
        m_since = 0;
        if (d == rr(SYNC, m_amt)) begin
          if (m_mode == 1) begin
            m_hits++;
            if (m_hits >= LH) go_lock(d);
          end else begin
            m_miss = 0;
            emit(d, 1);
          end
        end else if (m_mode == 1) m_mode = 0;
        else begin
          m_miss++;
          if (m_miss >= LM) begin m_mode = 0; e_lost = 1; end
          else emit(d, 0);
        end
      end else if (m_mode == 2) emit(d, 0);
    end
  endtask
  task automatic cycle(input bit v, input int d);
    in_valid = v;
    in_data = d[7:0];
    @(posedge clk);
    #1;
    model_step(v, d);
    chk("out_valid", out_valid, e_valid);
    chk("out_sof", out_sof, e_sof);
    chk("locked", locked, m_mode == 2);
    chk("lock_amt", lock_amt, e_amt);
    chk("lock_lost", lock_lost, e_lost);
    chk("out_data", out_data, e_data);
    if (v) vcount++;
    if (out_valid) emit_q.push_back(out_data);
    if (locked && lock_at < 0) lock_at = vcount;
    if (lock_lost) lost_cnt++;
  endtask
  task automatic word(input int d, input int maxgap);
    repeat ($urandom_range(maxgap, 0)) cycle(0, $urandom & 255);
    cycle(1, d);
  endtask
  task automatic frame(input int r, input int syncw, input int pay, input int maxgap);
    word(rr(syncw, r), maxgap);
    for (int i = 0; i < FL - 1; i++) word(rr(pay < 0 ? int'($urandom & 255) : pay, r), maxgap);
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_amt", lock_amt, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;
    vcount = 0; lock_at = -1; lost_cnt = 0;
    emit_q.delete();
  endtask
  task automatic test1(input int g);
    frame(3, SYNC, 'h0F, g);
    word(rr(SYNC, 3), g);
    chk("t1_locked", locked, 1);
    chk("t1_amt", lock_amt, 3);
    chk("t1_data", out_data, 'hA5);
    chk("t1_sof", out_sof, 1);
    for (int i = 0; i < FL - 1; i++) begin
      word('hE1, g);
      chk("t1_payload", out_data, 'h0F);
    end
    repeat (2) frame(3, SYNC, 'h0F, g);
  endtask
  initial begin
    do_reset();
    test1(0);
    q1 = emit_q;
    l1 = lock_at;
    do_reset();
    test1(3);
    chk("gap_lock_at", lock_at, l1);
    chk("gap_count", emit_q.size(), q1.size());
    for (int i = 0; i < q1.size() && i < emit_q.size(); i++) chk("gap_word", emit_q[i], q1[i]);
    do_reset();
    frame(0, SYNC, 'h0F, 0);
    word(SYNC, 0);
    chk("r0_amt", lock_amt, 0);
    chk("r0_data", out_data, SYNC);
    word('h0F, 0);
    chk("r0_payload", out_data, 'h0F);
    do_reset();
    frame(3, SYNC, 'h0F, 0);
    word(0, 0);
    chk("false_locked", locked, 0);
    chk("false_emits", emit_q.size(), 0);
    do_reset();
    repeat (2) frame(3, SYNC, 'h0F, 0);
    word(0, 0);
    chk("miss1_valid", out_valid, 1);
    chk("miss1_sof", out_sof, 0);
    chk("miss1_locked", locked, 1);
    for (int i = 0; i < FL - 1; i++) word('hE1, 0);
    frame(3, SYNC, 'h0F, 0);
    frame(3, 0, 'h0F, 0);
    chk("miss_lost_early", lost_cnt, 0);
    word(0, 0);
    chk("loss_pulse", lock_lost, 1);
    chk("loss_locked", locked, 0);
    chk("loss_not_emitted", out_valid, 0);
    cycle(0, 0);
    chk("loss_pulse_once", lost_cnt, 1);
    do_reset();
    repeat (2) frame(3, SYNC, 'h0F, 0);
    word('hE1, 0);
    chk("ar_pre_locked", locked, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_locked", locked, 0);
    chk("ar_valid", out_valid, 0);
    chk("ar_sof", out_sof, 0);
    chk("ar_amt", lock_amt, 0);
    model_reset();
    #4 rst_n = 1'b1;
    frame(3, SYNC, 'h0F, 0);
    chk("ar_relock_early", locked, 0);
    word(rr(SYNC, 3), 0);
    chk("ar_relock", locked, 1);
    for (int n = 0; n < 8; n++) begin
      int r;
      do_reset();
      r = $urandom_range(7, 0);
      for (int f = 0; f < 10; f++)
        frame(r, ($urandom_range(3, 0) == 0) ? int'($urandom & 255) : SYNC, -1, 2);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
